// File: rtl/eth_payload_extract.sv
// Payload extractor behind the Ethernet header parser: holds each payload byte, frames it with last/err
// and streams it through a first-word fall-through FIFO. Optional PAYLOAD_STATS_EN adds frame/error counters.
module eth_payload_extract #(
  parameter int FIFO_DEPTH = 16,
  parameter int MIN_LEN    = 46,
  parameter int MAX_LEN    = 1500,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data,
  input  logic       type_length_valid,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       m_err,
  output logic       busy
`ifdef PAYLOAD_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0] GUARD_MAX = CW'(FIFO_DEPTH - 2);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_LAST  = LW'(MAX_LEN - 1);
  localparam logic [LW-1:0] LEN_MIN   = LW'(MIN_LEN);
  localparam logic [GW-1:0] GAP_END   = GW'(GAP_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    PAYLOAD,
    END_MAX,
    DROP,
    SKIP
  } state_t;

  state_t state, state_nxt;

  logic [LW-1:0] byte_cnt, byte_cnt_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt, gap_inc;
  logic [7:0]    hold_byte_p0, hold_nxt;

  logic [9:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          push, pop, guard_ok;
  logic [9:0]    push_entry, rd_entry;

  function automatic logic [LW-1:0] sat_inc_len(input logic [LW-1:0] v);
    return (v == LEN_MAX) ? v : v + LW'(1);
  endfunction

  function automatic logic [GW-1:0] sat_inc_gap(input logic [GW-1:0] v);
    return (v == GAP_END) ? v : v + GW'(1);
  endfunction

  assign gap_inc  = sat_inc_gap(gap_cnt);
  assign guard_ok = (fifo_cnt <= GUARD_MAX);

  assign m_valid  = (fifo_cnt != '0);
  assign rd_entry = fifo_mem[rd_ptr];
  assign m_data   = m_valid ? rd_entry[7:0] : 8'h00;
  assign m_last   = m_valid & rd_entry[8];
  assign m_err    = m_valid & rd_entry[9];
  assign pop      = m_valid & m_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    gap_nxt      = gap_cnt;
    hold_nxt     = hold_byte_p0;
    push         = 1'b0;
    push_entry   = 10'h000;
    case (state)
      IDLE: begin
        if (enable && type_length_valid) begin
          hold_nxt     = data;
          byte_cnt_nxt = LW'(1);
          gap_nxt      = '0;
          state_nxt    = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (enable) begin
          gap_nxt      = '0;
          byte_cnt_nxt = sat_inc_len(byte_cnt);
          push         = 1'b1;
          if (!guard_ok) begin
            // Held byte is lost; the error beat lands in the slot kept free for it.
            push_entry = {1'b1, 1'b1, 8'h00};
            state_nxt  = DROP;
          end else begin
            push_entry = {1'b0, 1'b0, hold_byte_p0};
            hold_nxt   = data;
            if (byte_cnt == LEN_LAST) state_nxt = END_MAX;
          end
        end else begin
          gap_nxt = gap_inc;
          if (gap_inc == GAP_END) begin
            push       = 1'b1;
            push_entry = {(byte_cnt < LEN_MIN), 1'b1, hold_byte_p0};
            state_nxt  = IDLE;
          end
        end
      end
      END_MAX: begin
        push       = 1'b1;
        push_entry = {1'b0, 1'b1, hold_byte_p0};
        gap_nxt    = enable ? '0 : gap_inc;
        state_nxt  = SKIP;
      end
      DROP, SKIP: begin
        if (enable) begin
          gap_nxt = '0;
        end else begin
          gap_nxt = gap_inc;
          if (gap_inc == GAP_END) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: control state, byte/gap counters and FIFO pointers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      gap_cnt  <= gap_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    hold_byte_p0 <= hold_nxt;
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

`ifdef PAYLOAD_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count <= 16'h0000;
      err_count   <= 16'h0000;
    end else if (push && push_entry[8]) begin
      frame_count <= sat_inc16(frame_count);
      if (push_entry[9]) err_count <= sat_inc16(err_count);
    end
  end
`endif

endmodule

// File: tb/tb_eth_payload_extract.sv
// Directed bench for eth_payload_extract (MAX_LEN reduced to 64); beats are collected from the
// output stream and compared against hand-derived framing.
module tb_eth_payload_extract;
  logic       clock = 1'b0;
  logic       reset, enable, type_length_valid, m_ready;
  logic [7:0] data, m_data;
  logic       m_valid, m_last, m_err, busy;
`ifdef PAYLOAD_STATS_EN
  logic [15:0] frame_count, err_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int exp_frames = 0;
  int exp_errs = 0;
  logic [9:0] got_q[$];

  always #5 clock = ~clock;

  eth_payload_extract #(
    .FIFO_DEPTH(16), .MIN_LEN(46), .MAX_LEN(64), .GAP_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .data(data),
    .type_length_valid(type_length_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_err(m_err), .busy(busy)
`ifdef PAYLOAD_STATS_EN
    , .frame_count(frame_count), .err_count(err_count)
`endif
  );

  always @(negedge clock)
    if (!reset && m_valid && m_ready) got_q.push_back({m_err, m_last, m_data});

  task automatic drive(input logic en, input logic [7:0] d, input logic tlv);
    enable = en; data = d; type_length_valid = tlv;
    @(posedge clock); #1;
  endtask

  task automatic gap(input int n);
    enable = 1'b0; data = 8'h00; type_length_valid = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({m_valid, busy, m_last, m_err, m_data} !== 12'h000) begin
      $display("FAIL reset_outputs got=%h want=000", {m_valid, busy, m_last, m_err, m_data});
      tests_failed++;
    end
`ifdef PAYLOAD_STATS_EN
    tests_run++;
    if ({frame_count, err_count} !== 32'h0) begin
      $display("FAIL reset_stats got=%h want=0", {frame_count, err_count});
      tests_failed++;
    end
`endif
  endtask

  task automatic test_idle_ignore();
    got_q.delete(); m_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h30 + i), 1'b0);
    drive(1'b0, 8'h55, 1'b1);
    gap(6);
    tests_run++;
    if (busy !== 1'b0 || got_q.size() != 0) begin
      $display("FAIL idle_ignore busy=%b beats=%0d want busy=0 beats=0", busy, got_q.size());
      tests_failed++;
    end
  endtask

  task automatic test_payload_basic();
    got_q.delete(); m_ready = 1'b1;
    for (int i = 0; i < 46; i++) drive(1'b1, 8'(i), i == 0);
    gap(6);
    exp_frames++;
    tests_run++;
    if (got_q.size() != 46) begin
      $display("FAIL basic_count got=%0d want=46", got_q.size()); tests_failed++;
    end
    for (int i = 0; i < 46 && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== {1'b0, i == 45, 8'(i)}) begin
        $display("FAIL basic_beat%0d got=%h want=%h", i, got_q[i], {1'b0, i == 45, 8'(i)});
        tests_failed++;
      end
    end
    tests_run++;
    if (busy !== 1'b0) begin $display("FAIL basic_busy got=%b want=0", busy); tests_failed++; end
  endtask

  task automatic test_runt();
    int lens[3] = '{10, 1, 45};
    m_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      got_q.delete();
      for (int i = 0; i < lens[f]; i++) drive(1'b1, 8'(8'hA0 + i), i == 0);
      gap(6);
      exp_frames++; exp_errs++;
      tests_run++;
      if (got_q.size() != lens[f]) begin
        $display("FAIL runt%0d_count got=%0d want=%0d", lens[f], got_q.size(), lens[f]);
        tests_failed++;
      end
      for (int i = 0; i < lens[f] && i < got_q.size(); i++) begin
        tests_run++;
        if (got_q[i] !== {i == lens[f] - 1, i == lens[f] - 1, 8'(8'hA0 + i)}) begin
          $display("FAIL runt%0d_beat%0d got=%h want=%h", lens[f], i, got_q[i],
                   {i == lens[f] - 1, i == lens[f] - 1, 8'(8'hA0 + i)});
          tests_failed++;
        end
      end
    end
`ifdef PAYLOAD_STATS_EN
    tests_run++;
    if (frame_count !== 16'(exp_frames) || err_count !== 16'(exp_errs)) begin
      $display("FAIL runt_stats got=%0d/%0d want=%0d/%0d", frame_count, err_count, exp_frames, exp_errs);
      tests_failed++;
    end
`endif
  endtask

  task automatic test_overflow();
    got_q.delete(); m_ready = 1'b0;
    for (int i = 0; i < 40; i++) drive(1'b1, 8'(i), i == 0);
    tests_run++;
    if ({m_valid, m_err, m_last, m_data} !== 11'h400 || got_q.size() != 0) begin
      $display("FAIL ovf_stall got=%h beats=%0d want=400 beats=0", {m_valid, m_err, m_last, m_data}, got_q.size());
      tests_failed++;
    end
    gap(2);
    tests_run++;
    if (busy !== 1'b1 || m_data !== 8'h00) begin
      $display("FAIL ovf_busy_hold busy=%b data=%h want busy=1 data=00", busy, m_data); tests_failed++;
    end
    m_ready = 1'b1;
    gap(20);
    exp_frames++; exp_errs++;
    tests_run++;
    if (got_q.size() != 16) begin
      $display("FAIL ovf_count got=%0d want=16", got_q.size()); tests_failed++;
    end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== ((i == 15) ? 10'h300 : {2'b00, 8'(i)})) begin
        $display("FAIL ovf_beat%0d got=%h want=%h", i, got_q[i], (i == 15) ? 10'h300 : {2'b00, 8'(i)});
        tests_failed++;
      end
    end
    tests_run++;
    if (busy !== 1'b0) begin $display("FAIL ovf_idle busy=%b want=0", busy); tests_failed++; end
  endtask

  task automatic test_max_len();
    got_q.delete(); m_ready = 1'b1;
    for (int i = 0; i < 100; i++) drive(1'b1, 8'(i), i == 0);
    gap(6);
    exp_frames++;
    tests_run++;
    if (got_q.size() != 64) begin
      $display("FAIL max_count got=%0d want=64", got_q.size()); tests_failed++;
    end
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== {1'b0, i == 63, 8'(i)}) begin
        $display("FAIL max_beat%0d got=%h want=%h", i, got_q[i], {1'b0, i == 63, 8'(i)});
        tests_failed++;
      end
    end
`ifdef PAYLOAD_STATS_EN
    tests_run++;
    if (frame_count !== 16'(exp_frames) || err_count !== 16'(exp_errs)) begin
      $display("FAIL max_stats got=%0d/%0d want=%0d/%0d", frame_count, err_count, exp_frames, exp_errs);
      tests_failed++;
    end
`endif
  endtask

  task automatic test_reset_mid();
    got_q.delete(); m_ready = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(8'h10 + i), i == 0);
    tests_run++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL rst_pre valid=%b busy=%b want 1/1", m_valid, busy); tests_failed++;
    end
    enable = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_frames = 0; exp_errs = 0;
    tests_run++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL rst_post valid=%b busy=%b want 0/0", m_valid, busy); tests_failed++;
    end
    m_ready = 1'b1;
    for (int i = 0; i < 50; i++) drive(1'b1, 8'(8'h80 + i), i == 0);
    gap(6);
    exp_frames++;
    tests_run++;
    if (got_q.size() != 50) begin
      $display("FAIL rst_next_count got=%0d want=50", got_q.size()); tests_failed++;
    end
    for (int i = 0; i < 50 && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== {1'b0, i == 49, 8'(8'h80 + i)}) begin
        $display("FAIL rst_next_beat%0d got=%h want=%h", i, got_q[i], {1'b0, i == 49, 8'(8'h80 + i)});
        tests_failed++;
      end
    end
  endtask

  task automatic test_mid_tlv_gaps();
    got_q.delete(); m_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 8'(i), (i == 0) || (i == 20) || (i == 40));
      if (i == 15 || i == 35) gap(3);
    end
    gap(6);
    exp_frames++;
    tests_run++;
    if (got_q.size() != 60) begin
      $display("FAIL gaps_count got=%0d want=60", got_q.size()); tests_failed++;
    end
    for (int i = 0; i < 60 && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== {1'b0, i == 59, 8'(i)}) begin
        $display("FAIL gaps_beat%0d got=%h want=%h", i, got_q[i], {1'b0, i == 59, 8'(i)});
        tests_failed++;
      end
    end
`ifdef PAYLOAD_STATS_EN
    tests_run++;
    if (frame_count !== 16'(exp_frames) || err_count !== 16'(exp_errs)) begin
      $display("FAIL gaps_stats got=%0d/%0d want=%0d/%0d", frame_count, err_count, exp_frames, exp_errs);
      tests_failed++;
    end
`endif
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; data = 8'h00; type_length_valid = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    test_idle_ignore();
    test_payload_basic();
    test_runt();
    test_overflow();
    test_max_len();
    test_reset_mid();
    test_mid_tlv_gaps();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
